// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// Optional bus timeout is enabled with the WBM_TIMEOUT_EN macro.
package wb_cmd_master_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 7;
    localparam int CNT_W      = 8;
    localparam int HDR_WE_BIT = 7;

    localparam logic [DATA_W-1:0] STATUS_OK      = 8'h00;
    localparam logic [DATA_W-1:0] STATUS_TIMEOUT = 8'h01;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WDATA,
        ST_BUS,
        ST_RDATA_TX,
        ST_STATUS_TX
    } state_t;

    // A zero length field encodes the maximum burst of 128 bytes.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, len};
    endfunction

endpackage

// File: rtl/wb_cmd_master_timeout_ctr.sv
// Bus-cycle watchdog: cleared by load, counts while count is high, and
// flags expire on the TIMEOUT_CYCLES-th counted cycle (WBM_TIMEOUT_EN only).
module wbm_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CTR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CTR_W-1:0] ctr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            ctr <= '0;
        end else if (count && !expire) begin
            ctr <= ctr + 1'b1;
        end
    end

    assign expire = count && (ctr == CTR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Host byte-stream to Wishbone single-beat initiator with read-data/status return.
// Define WBM_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT_CYCLES.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    state_t            state, next_state;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    logic              stb_q;
    logic              err;
    logic              rx_fire, tx_fire, ack, timeout, beat_done;

    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign ack       = (state == ST_BUS) && stb_q && wb_ack_i;
    assign beat_done = ack || timeout;

`ifdef WBM_TIMEOUT_EN
    wbm_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (!stb_q),
        .count  (stb_q),
        .expire (timeout)
    );
`else
    // The limit only has meaning in the timeout build.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HDR;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        rx_ready   = !rst && (state inside {ST_HDR, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA});
        tx_valid   = (state == ST_RDATA_TX) || (state == ST_STATUS_TX);
        tx_data    = rdat;
        unique case (state)
            ST_HDR:     if (rx_fire) next_state = ST_ADDR_HI;
            ST_ADDR_HI: if (rx_fire) next_state = ST_ADDR_LO;
            ST_ADDR_LO: if (rx_fire) next_state = we_q ? ST_WDATA : ST_BUS;
            ST_WDATA:   if (rx_fire) next_state = ST_BUS;
            ST_BUS: begin
                if (beat_done) begin
                    if (!we_q)                    next_state = ST_RDATA_TX;
                    else if (cnt != CNT_W'(1))    next_state = ST_WDATA;
                    else                          next_state = ST_STATUS_TX;
                end
            end
            ST_RDATA_TX: if (tx_fire) next_state = (cnt != '0) ? ST_BUS : ST_STATUS_TX;
            ST_STATUS_TX: begin
                tx_data = err ? STATUS_TIMEOUT : STATUS_OK;
                if (tx_fire) next_state = ST_HDR;
            end
            default: next_state = ST_HDR;
        endcase
    end

    // Strobe is registered from the next state, so it rises on BUS entry and
    // falls on the edge that completes the beat; every exit from BUS leaves it low.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q  <= 1'b0;
            cnt   <= '0;
            adr   <= '0;
            wdat  <= '0;
            rdat  <= '0;
            stb_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            stb_q <= (next_state == ST_BUS);
            unique case (state)
                ST_HDR: if (rx_fire) begin
                    we_q <= rx_data[HDR_WE_BIT];
                    cnt  <= len_to_count(rx_data[LEN_W-1:0]);
                end
                ST_ADDR_HI: if (rx_fire) adr[ADDR_W-1:DATA_W] <= rx_data;
                ST_ADDR_LO: if (rx_fire) begin
                    adr[DATA_W-1:0] <= rx_data;
                    err             <= 1'b0;
                end
                ST_WDATA: if (rx_fire) wdat <= rx_data;
                ST_BUS: if (beat_done) begin
                    cnt <= cnt - 1'b1;
                    adr <= adr + 1'b1;
                    if (timeout) begin
                        err  <= 1'b1;
                        rdat <= '0;
                    end else if (!we_q) begin
                        rdat <= wb_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_adr_o = adr;
    assign wb_dat_o = wdat;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: behavioural Wishbone slave, byte
// stream driver and a transaction-level model of the command protocol.
`timescale 1ns/1ps
module tb_wb_cmd_master;

    localparam int TO_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [15:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o, wb_stb_o, wb_cyc_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_ack_i = 1'b0;

    wb_cmd_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [7:0]  dat;
        int          cycles;
        bit          acked;
        bit          stable;
    } bus_op_t;

    bus_op_t    act_ops[$];
    bus_op_t    exp_ops[$];
    logic [7:0] act_tx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] wdata_q[$];
    logic [7:0] mem[65536];
    logic [7:0] ref_mem[65536];

    int checks = 0;
    int failures = 0;
    int ack_wait = 1;
    bit ack_never = 1'b0;

    // Slave and stream monitor, all sampling on the falling edge.
    bus_op_t cur;
    int      wait_cnt = 0;
    logic    prev_stb = 1'b0;
    int      low_run = 0;
    int      min_gap = 1000;
    bit      seen_op = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stb = 1'b0;
            wb_ack_i = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wb_stb_o) begin
                if (!prev_stb) begin
                    cur.adr = wb_adr_o; cur.we = wb_we_o; cur.dat = wb_dat_o;
                    cur.cycles = 0; cur.acked = 1'b0; cur.stable = 1'b1;
                    wait_cnt = 0;
                    if (seen_op && low_run < min_gap) min_gap = low_run;
                end else if (wb_adr_o !== cur.adr || wb_we_o !== cur.we || wb_dat_o !== cur.dat) begin
                    cur.stable = 1'b0;
                end
                cur.cycles++;
                if (!ack_never && !wb_ack_i && wait_cnt == ack_wait) begin
                    wb_ack_i  = 1'b1;
                    cur.acked = 1'b1;
                    if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
                    else         wb_dat_i = mem[wb_adr_o];
                end else begin
                    wb_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wb_ack_i = 1'b0;
                if (prev_stb) begin
                    act_ops.push_back(cur);
                    seen_op = 1'b1;
                    low_run = 0;
                end
                low_run++;
            end
            prev_stb = wb_stb_o;
            if (tx_valid && tx_ready) act_tx.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = rx_ready;
            tick();
        end
        rx_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL rx_accept: byte %02h not taken (rx_ready=%b) within 2000 cycles", b, rx_ready);
        end
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int i = 0;
        while (act_tx.size() < n && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (act_tx.size() < n) begin
            failures++;
            $display("FAIL %s tx_timeout: got %0d bytes, expected %0d", name, act_tx.size(), n);
        end
    endtask

    // Issues one command, builds its expected bus beats and response bytes
    // from the protocol rules, then compares against what was observed.
    task automatic run_cmd(input string name, input bit we, input logic [6:0] len,
                           input logic [15:0] adr, input int wait_c);
        int n = (len == 7'd0) ? 128 : int'(len);
        logic [7:0] wbytes[$];
        bus_op_t e;
        act_ops.delete(); act_tx.delete(); exp_ops.delete(); exp_tx.delete();
        ack_wait = wait_c;
        for (int i = 0; i < n; i++) begin
            e.adr = adr + 16'(i); e.we = we; e.dat = 8'h00;
            e.cycles = wait_c + 1; e.acked = 1'b1; e.stable = 1'b1;
            if (we) begin
                e.dat = (wdata_q.size() != 0) ? wdata_q.pop_front() : 8'($urandom);
                ref_mem[e.adr] = e.dat;
                wbytes.push_back(e.dat);
            end else begin
                exp_tx.push_back(ref_mem[e.adr]);
            end
            exp_ops.push_back(e);
        end
        exp_tx.push_back(8'h00);
        send_byte({we, len});
        send_byte(adr[15:8]);
        send_byte(adr[7:0]);
        foreach (wbytes[i]) send_byte(wbytes[i]);
        wait_tx(exp_tx.size(), 6000, name);
        repeat (4) tick();

        checks++;
        if (act_ops.size() != exp_ops.size()) begin
            failures++;
            $display("FAIL %s bus_count: got %0d, expected %0d", name, act_ops.size(), exp_ops.size());
        end
        for (int i = 0; i < exp_ops.size() && i < act_ops.size(); i++) begin
            bus_op_t a = act_ops[i];
            e = exp_ops[i];
            checks++;
            if (a.adr !== e.adr || a.we !== e.we || a.cycles != e.cycles || !a.acked || !a.stable
                || (e.we && a.dat !== e.dat)) begin
                failures++;
                $display("FAIL %s bus[%0d]: got adr=%04h we=%b dat=%02h stb_cycles=%0d acked=%b stable=%b, expected adr=%04h we=%b dat=%02h stb_cycles=%0d acked=1 stable=1",
                         name, i, a.adr, a.we, a.dat, a.cycles, a.acked, a.stable,
                         e.adr, e.we, e.dat, e.cycles);
            end
        end
        checks++;
        if (act_tx.size() != exp_tx.size()) begin
            failures++;
            $display("FAIL %s tx_count: got %0d, expected %0d", name, act_tx.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++) begin
            checks++;
            if (act_tx[i] !== exp_tx[i]) begin
                failures++;
                $display("FAIL %s tx[%0d]: got %02h, expected %02h", name, i, act_tx[i], exp_tx[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, wb_stb_o, wb_cyc_o, wb_we_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rx_ready=%b tx_valid=%b stb=%b cyc=%b we=%b, expected all 0",
                     rx_ready, tx_valid, wb_stb_o, wb_cyc_o, wb_we_o);
        end
        checks++;
        if (tx_data !== 8'h00 || wb_adr_o !== 16'h0000 || wb_dat_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got tx_data=%02h adr=%04h dat=%02h, expected 00/0000/00",
                     tx_data, wb_adr_o, wb_dat_o);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hdr_ready: got rx_ready=%b, expected 1", rx_ready);
        end
        tick();
    endtask

    task automatic test_write();
        wdata_q.delete();
        wdata_q.push_back(8'hAA);
        wdata_q.push_back(8'hBB);
        run_cmd("write", 1'b1, 7'd2, 16'h1234, 1);
    endtask

    // Read with 3 wait states; the first returned byte is held off for 10 cycles.
    task automatic test_read();
        logic [7:0] held;
        bit seen = 1'b0;
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33;
        ref_mem[16'h0020] = 8'h11; ref_mem[16'h0021] = 8'h22; ref_mem[16'h0022] = 8'h33;
        min_gap = 1000;
        seen_op = 1'b0;
        fork
            run_cmd("read", 1'b0, 7'd3, 16'h0020, 3);
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    tick();
                    seen = tx_valid;
                end
                checks++;
                if (!seen) begin
                    failures++;
                    $display("FAIL backpressure_start: tx_valid never rose");
                end
                tx_ready = 1'b0;
                held     = tx_data;
                rx_data  = 8'hC3;
                rx_valid = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== held || wb_stb_o !== 1'b0
                        || wb_cyc_o !== 1'b0 || rx_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL backpressure[%0d]: got tx_valid=%b tx_data=%02h stb=%b cyc=%b rx_ready=%b, expected 1/%02h/0/0/0",
                                 i, tx_valid, tx_data, wb_stb_o, wb_cyc_o, rx_ready, held);
                    end
                end
                rx_valid = 1'b0;
                tx_ready = 1'b1;
            end
        join
        checks++;
        if (min_gap < 1) begin
            failures++;
            $display("FAIL read_idle_gap: got %0d idle cycles between beats, expected >= 1", min_gap);
        end
    endtask

    task automatic test_wrap();
        run_cmd("wrap_burst128", 1'b0, 7'd0, 16'hFFFF, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_cmd($sformatf("random%0d", k), 1'($urandom), 7'($urandom_range(1, 6)),
                    16'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_timeout();
`ifdef WBM_TIMEOUT_EN
        act_ops.delete(); act_tx.delete();
        ack_never = 1'b1;
        send_byte(8'h01); send_byte(8'h30); send_byte(8'h00);
        wait_tx(2, 500, "timeout");
        repeat (4) tick();
        ack_never = 1'b0;
        checks++;
        if (act_ops.size() != 1) begin
            failures++;
            $display("FAIL timeout_bus_count: got %0d, expected 1", act_ops.size());
        end else begin
            checks++;
            if (act_ops[0].cycles != TO_CYCLES || act_ops[0].acked || act_ops[0].adr !== 16'h3000) begin
                failures++;
                $display("FAIL timeout_bus: got adr=%04h stb_cycles=%0d acked=%b, expected adr=3000 stb_cycles=%0d acked=0",
                         act_ops[0].adr, act_ops[0].cycles, act_ops[0].acked, TO_CYCLES);
            end
        end
        checks++;
        if (act_tx.size() != 2 || act_tx[0] !== 8'h00 || act_tx[1] !== 8'h01) begin
            failures++;
            $display("FAIL timeout_tx: got %0d bytes first=%02h last=%02h, expected 2 bytes 00 01",
                     act_tx.size(), (act_tx.size() > 0) ? act_tx[0] : 8'hxx,
                     (act_tx.size() > 1) ? act_tx[1] : 8'hxx);
        end
        run_cmd("after_timeout", 1'b0, 7'd1, 16'h3001, 1);
`endif
    endtask

    task automatic test_reset_mid_burst();
        int i = 0;
        act_ops.delete(); act_tx.delete();
        ack_never = 1'b1;
        send_byte(8'h84); send_byte(8'h40); send_byte(8'h00); send_byte(8'h5A);
        while (!wb_stb_o && i < 100) begin
            tick();
            i++;
        end
        checks++;
        if (!wb_stb_o) begin
            failures++;
            $display("FAIL reset_mid_stb: got stb=%b before reset, expected 1", wb_stb_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drop: got stb=%b cyc=%b tx_valid=%b, expected 0/0/0",
                     wb_stb_o, wb_cyc_o, tx_valid);
        end
        ack_never = 1'b0;
        act_tx.delete();
        repeat (20) tick();
        checks++;
        if (act_tx.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_no_status: got %0d tx bytes, expected 0", act_tx.size());
        end
        wdata_q.delete();
        wdata_q.push_back(8'h7E);
        run_cmd("after_reset", 1'b1, 7'd1, 16'h0005, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone initiator that drives the per-channel register slaves (8-bit data, 16-bit address, classic single-beat stb/cyc/ack).
- Parses a host command byte stream (header, address, optional write data) into sequential bus cycles.
- Returns read data and a status byte on an outbound byte stream.
- Sits between the host transport (UART/USB byte FIFO) and the Wishbone address decoder feeding the ADC channel blocks.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for wb_ack_i before aborting a bus cycle; used only with WBM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  inbound command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_data  out  8  outbound response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte consumed when tx_valid && tx_ready
- wb_adr_o  out  16  bus address
- wb_dat_o  out  8  write data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, wb_stb_o=0, wb_cyc_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, error flag=0, state=HDR.
- Command format: header byte [7]=we, [6:0]=len. len 0 means 128 bytes. Then addr_hi, then addr_lo. Writes follow with len data bytes.
- States: HDR, ADDR_HI, ADDR_LO, WDATA, BUS, RDATA_TX, STATUS_TX.
- rx_ready is 1 only in HDR, ADDR_HI, ADDR_LO and WDATA.
- HDR: accept byte; latch we and len; go to ADDR_HI.
- ADDR_HI: accept byte as address bits [15:8]; go to ADDR_LO.
- ADDR_LO: accept byte as address bits [7:0]; clear the error flag; go to WDATA if write, else BUS.
- WDATA: accept byte into wb_dat_o; go to BUS.
- BUS: wb_cyc_o=wb_stb_o=1 starting the cycle after BUS is entered. Held with address, data and we stable until wb_ack_i=1.
  - On the ack cycle, latch wb_dat_i (reads), drop stb/cyc on the next edge, and decrement the remaining count.
  - Read: go to RDATA_TX.
  - Write: go to WDATA if bytes remain, else STATUS_TX.
  - Every bus cycle is separated by at least one cycle with stb/cyc low.
- RDATA_TX: tx_valid=1 with the latched byte, held stable until tx_ready. Then go to BUS if bytes remain, else STATUS_TX.
- STATUS_TX: tx_valid=1, tx_data=0x00 (ok) or 0x01 (error flag set). On tx_ready go to HDR.
- Address increments by 1 after each bus cycle, 16-bit wrap (0xFFFF -> 0x0000). The count is 8 bits wide so it can hold 128.
- Reads emit len data bytes then one status byte. Writes emit only the status byte.
- rx bytes arriving while rx_ready=0 are not consumed; there is no drop or overflow.
- wb_ack_i while stb is low is ignored.
- Reset mid-operation: stb/cyc and tx_valid are low on the cycle after rst is sampled. Any partial command is discarded and the state returns to HDR.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- With the macro: a counter runs while in BUS. If it reaches TIMEOUT_CYCLES without an ack:
  - stb/cyc drop and the error flag is set;
  - a read substitutes data 0x00;
  - the command then continues normally, so the byte count and address increment are unchanged.
- Without the macro: BUS waits indefinitely, the error flag is never set, and status is always 0x00.

Decomposition:
- Shared package holds:
  - state enum;
  - STATUS_OK=8'h00 and STATUS_TIMEOUT=8'h01;
  - HDR_WE_BIT=7;
  - LEN field width of 7;
  - address width 16 and data width 8.
- One natural sub-module: wbm_timeout_ctr (load/count/expire), instantiated only under WBM_TIMEOUT_EN.

Test Plan:
- Write: send 0x82,0x12,0x34,0xAA,0xBB with the slave acking after 1 cycle.
  - Expect two write cycles, at 0x1234 data 0xAA and at 0x1235 data 0xBB.
  - Then tx 0x00.
- Read: send 0x03,0x00,0x20 with the slave returning 0x11,0x22,0x33 and acking after 3 wait cycles.
  - Expect tx 0x11,0x22,0x33,0x00.
  - stb is held through the wait cycles, and there is one idle cycle between beats.
- Wrap and long burst: read header 0x00 at address 0xFFFF.
  - Expect 128 bus cycles at 0xFFFF, then 0x0000..0x007E.
  - Expect 129 tx bytes.
- Backpressure: during the read test, hold tx_ready=0 for 10 cycles.
  - tx_data/tx_valid stay stable, no new bus cycle starts, and no rx bytes are consumed.
- Timeout (macro on, TIMEOUT_CYCLES=8): read 1 byte with no ack.
  - stb drops after 8 cycles.
  - tx 0x00 (data), then 0x01 (status).
  - A following command reports 0x00 status.
- Reset mid-burst: assert rst while stb=1 in a 4-byte write.
  - stb/cyc are 0 the next cycle and no status is sent.
  - A new command 0x81,0x00,0x05,0x7E completes normally.
